// File: rtl/symbol_timing_nco.sv
// Symbol-timing NCO: PI loop filter driving a modulo-2^WA phase accumulator that
// strobes once per symbol with the fractional interval mu. Optional lock detector under NCO_LOCK_DET_EN.
module symbol_timing_nco #(
  parameter int OSF      = 20,
  parameter int WE       = 18,
  parameter int WA       = 32,
  parameter int WMU      = 16,
  parameter int KP_SHIFT = 4,
  parameter int KI_SHIFT = 8,
  parameter int INT_LIM  = 2**20,
  parameter int CTRL_LIM = 2**24,
  parameter int LOCK_THR = 512,
  parameter int LOCK_CNT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [WE-1:0] e_in,
  input  logic                 e_valid_i,
  input  logic                 iq_val,
  output logic                 sym_valid_o,
  output logic [WMU-1:0]       mu_o,
  output logic signed [WA-1:0] ctrl_o,
  output logic                 lock_o
);

  localparam longint unsigned STEP_L =
    ((64'd1 << WA) + 64'(OSF) - 64'd1) / 64'(OSF);
  localparam logic [WA-1:0]     STEP       = WA'(STEP_L);
  localparam logic signed [WA:0] INT_LIM_W  = (WA+1)'(INT_LIM);
  localparam logic signed [WA:0] CTRL_LIM_W = (WA+1)'(CTRL_LIM);

  function automatic logic signed [WA-1:0] sat_lim(input logic signed [WA:0] x,
                                                   input logic signed [WA:0] lim);
    logic signed [WA:0] nlim;
    nlim = -lim;
    if (x > lim)       sat_lim = lim[WA-1:0];
    else if (x < nlim) sat_lim = nlim[WA-1:0];
    else               sat_lim = x[WA-1:0];
  endfunction

  logic signed [WA-1:0] integ;
  logic [WA-1:0]        acc;

  logic signed [WA-1:0] e_ext;
  logic signed [WA-1:0] e_kp;
  logic signed [WA-1:0] e_ki;
  logic signed [WA:0]   integ_sum;
  logic signed [WA-1:0] integ_next;
  logic signed [WA:0]   ctrl_sum;
  logic signed [WA-1:0] ctrl_next;
  logic [WA+1:0]        acc_sum;
  logic [WA-1:0]        acc_new;
  logic                 wrap;

  // Loop filter: both terms are summed one bit wider so saturation sees the true value
  always_comb begin
    e_ext      = {{(WA-WE){e_in[WE-1]}}, e_in};
    e_kp       = e_ext >>> KP_SHIFT;
    e_ki       = e_ext >>> KI_SHIFT;
    integ_sum  = {integ[WA-1], integ} + {e_ki[WA-1], e_ki};
    integ_next = sat_lim(integ_sum, INT_LIM_W);
    ctrl_sum   = {e_kp[WA-1], e_kp} + {integ_next[WA-1], integ_next};
    ctrl_next  = sat_lim(ctrl_sum, CTRL_LIM_W);
  end

  // Phase accumulator: two guard bits separate a real carry from a negative sum
  always_comb begin
    acc_sum = {2'b00, acc} + {2'b00, STEP} + {{2{ctrl_o[WA-1]}}, ctrl_o};
    acc_new = acc_sum[WA-1:0];
    wrap    = (acc_sum[WA+1:WA] == 2'b01) || (acc_new == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      integ       <= '0;
      ctrl_o      <= '0;
      acc         <= '0;
      mu_o        <= '0;
      sym_valid_o <= 1'b0;
    end else begin
      if (e_valid_i) begin
        integ  <= integ_next;
        ctrl_o <= ctrl_next;
      end
      sym_valid_o <= 1'b0;
      if (iq_val) begin
        acc <= acc_new;
        if (wrap) begin
          mu_o        <= acc_new[WA-1 -: WMU];
          sym_valid_o <= ~sym_valid_o;
        end
      end
    end
  end

`ifdef NCO_LOCK_DET_EN
  localparam int CW = $clog2(LOCK_CNT + 1);

  logic [CW-1:0] lock_cnt;
  logic [WE:0]   e_abs;
  logic          e_small;

  always_comb begin
    e_abs   = e_in[WE-1] ? -{e_in[WE-1], e_in} : {e_in[WE-1], e_in};
    e_small = (e_abs < (WE+1)'(LOCK_THR));
  end

  // Lock detector: run of small errors; one large error drops lock immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
      lock_o   <= 1'b0;
    end else if (e_valid_i && !e_small) begin
      lock_cnt <= '0;
      lock_o   <= 1'b0;
    end else begin
      if (e_valid_i && (lock_cnt != CW'(LOCK_CNT)))
        lock_cnt <= lock_cnt + 1'b1;
      lock_o <= (lock_cnt == CW'(LOCK_CNT));
    end
  end
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_symbol_timing_nco.sv
// Directed bench for symbol_timing_nco at default parameters; expected values are hand-computed.
module tb_symbol_timing_nco;

  logic               clk;
  logic               reset;
  logic signed [17:0] e_in;
  logic               e_valid_i;
  logic               iq_val;
  logic               sym_valid_o;
  logic [15:0]        mu_o;
  logic signed [31:0] ctrl_o;
  logic               lock_o;

  int vectors;
  int miscompares;
  int n;

  symbol_timing_nco dut (
    .clk        (clk),
    .reset      (reset),
    .e_in       (e_in),
    .e_valid_i  (e_valid_i),
    .iq_val     (iq_val),
    .sym_valid_o(sym_valid_o),
    .mu_o       (mu_o),
    .ctrl_o     (ctrl_o),
    .lock_o     (lock_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic iq, input logic ev,
                      input logic signed [17:0] e);
    reset     = r;
    iq_val    = iq;
    e_valid_i = ev;
    e_in      = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    iq_val      = 1'b0;
    e_valid_i   = 1'b0;
    e_in        = '0;

    // reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 18'sd1000);
    chk("rst_sym", sym_valid_o, 0);
    chk("rst_mu", mu_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_lock", lock_o, 0);

    // free run: strobe on every 20th iq_val, mu stays 0 (acc residue grows by 4 per symbol)
    n = 0;
    for (int c = 0; c < 20000; c++) begin
      step(0, 1, 0, 0);
      n++;
      chk("free_sym", sym_valid_o, (n % 20) == 0);
      if ((n % 20) == 0) chk("free_mu", mu_o, 0);
    end

    // gapped iq_val: strobe only right after the 20th accepted sample
    step(1, 0, 0, 0);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      step(0, (c % 2) == 0, 0, 0);
      if ((c % 2) == 0) n++;
      chk("gap_sym", sym_valid_o, ((c % 2) == 0) && ((n % 20) == 0));
    end

    // loop filter: e=256 -> kp term 16, ki term 1 per pulse
    step(1, 0, 0, 0);
    chk("loop_ctrl0", ctrl_o, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 1, 18'sd256);
      chk("loop_ctrl", ctrl_o, 16 + k);
    end
    step(0, 0, 0, 18'sd5000);
    chk("loop_hold", ctrl_o, 26);

    // positive saturation: integ clamps at 2^20, ctrl = 8191 + 2^20
    step(1, 0, 0, 0);
    for (int k = 0; k < 10000; k++) step(0, 0, 1, 18'sd131071);
    chk("sat_pos_ctrl", ctrl_o, 1056767);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sat_pos_hold", ctrl_o, 1056767);

    // with ctrl=1056767 from acc=0 the 20th sample wraps to 21135344 -> mu=322
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, 0);
      chk("ctrl_sym", sym_valid_o, i == 20);
    end
    chk("ctrl_mu", mu_o, 322);
    step(0, 0, 0, 0);
    chk("ctrl_sym_once", sym_valid_o, 0);
    chk("ctrl_mu_hold", mu_o, 322);

    // negative saturation: -131071 >>> 8 = -512, >>> 4 = -8192
    for (int k = 0; k < 10000; k++) step(0, 0, 1, -18'sd131071);
    chk("sat_neg_ctrl", ctrl_o, -1056768);

    // mid-run reset overrides coincident e_valid_i and iq_val
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("mid_pre_mu", mu_o, 322);
    step(1, 1, 1, 18'sd4000);
    chk("mid_sym", sym_valid_o, 0);
    chk("mid_mu", mu_o, 0);
    chk("mid_ctrl", ctrl_o, 0);
    chk("mid_lock", lock_o, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, 0);
      chk("mid_sym_after", sym_valid_o, i == 20);
    end

    // lock detector
    step(1, 0, 0, 0);
    for (int k = 1; k <= 64; k++) begin
      step(0, 0, 1, 18'sd100);
      chk("lock_run", lock_o, 0);
    end
    step(0, 0, 0, 0);
`ifdef NCO_LOCK_DET_EN
    chk("lock_set", lock_o, 1);
`else
    chk("lock_set", lock_o, 0);
`endif
    step(0, 0, 1, 18'sd600);
    chk("lock_drop", lock_o, 0);
    step(0, 0, 0, 0);
    chk("lock_drop_hold", lock_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/symbol_timing_nco.md
SYMBOL_TIMING_NCO -- requirements
Module: symbol_timing_nco

Interface
REQ-001 SHALL have parameter OSF, default 20, samples per symbol.
REQ-002 SHALL have parameter WE, default 18, width of the signed timing-error input.
REQ-003 SHALL have parameter WA, default 32, phase-accumulator and control width.
REQ-004 SHALL have parameter WMU, default 16, fractional-interval output width.
REQ-005 SHALL have parameters KP_SHIFT (default 4) and KI_SHIFT (default 8), the proportional and integral arithmetic right-shifts.
REQ-006 SHALL have parameter INT_LIM, default 2^20, the integrator symmetric saturation magnitude.
REQ-007 SHALL have parameter CTRL_LIM, default 2^24, the control-word symmetric saturation magnitude.
REQ-008 SHALL have parameters LOCK_THR (default 512) and LOCK_CNT (default 64), the lock-detector error threshold and run length.
REQ-009 Ports: clk  in  1  sole clock; all logic on its rising edge.
REQ-010 Ports: reset  in  1  synchronous, active-high reset.
REQ-011 Ports: e_in  in  WE signed  timing error from the Gardner TED.
REQ-012 Ports: e_valid_i  in  1  e_in qualifier, one-cycle pulse per symbol.
REQ-013 Ports: iq_val  in  1  input-sample strobe; the accumulator advances only when it is high.
REQ-014 Ports: sym_valid_o  out  1  one-cycle symbol strobe to the TED and interpolator.
REQ-015 Ports: mu_o  out  WMU unsigned  fractional interval, valid with sym_valid_o.
REQ-016 Ports: ctrl_o  out  WA signed  loop-filter output.
REQ-017 Ports: lock_o  out  1  timing-lock indicator.

Function
REQ-018 STEP SHALL be the constant ceil(2^WA/OSF); for example, 214748365 for the defaults.
REQ-019 When e_valid_i is high, the block SHALL compute integ_next = sat_INT_LIM(integ + (e_in >>> KI_SHIFT)), after sign-extending e_in to WA.
REQ-020 In the same cycle, the block SHALL register ctrl_o <= sat_CTRL_LIM((e_in >>> KP_SHIFT) + integ_next), giving a latency of exactly 1 clock from e_valid_i.
REQ-021 When e_valid_i is low, integ and ctrl_o SHALL hold their values.
REQ-022 Saturation SHALL clamp to +LIM or -LIM and SHALL never wrap.
REQ-023 On each iq_val, the accumulator SHALL update as acc <= (acc + STEP + ctrl_o) mod 2^WA, using the registered ctrl_o.
REQ-024 When e_valid_i and iq_val coincide, the accumulator SHALL use the old ctrl_o.
REQ-025 A carry out of bit WA-1 SHALL be a wrap; an exact result of 0 SHALL also count as a wrap.
REQ-026 On a wrap, the block SHALL assert sym_valid_o for exactly 1 cycle, on the cycle after the causing iq_val.
REQ-027 On a wrap, the block SHALL register mu_o <= acc_new[WA-1 -: WMU].
REQ-028 mu_o SHALL hold its value between wraps.
REQ-029 Without iq_val, the block SHALL NOT assert sym_valid_o and the accumulator SHALL hold.
REQ-030 sym_valid_o SHALL never assert on two consecutive cycles.

Reset
REQ-031 While reset is high, acc, integ, ctrl_o, mu_o, the lock counter and lock_o SHALL be cleared to 0, and sym_valid_o SHALL be 0.
REQ-032 A reset asserted mid-operation SHALL take effect on the next edge and SHALL override coincident e_valid_i and iq_val.
REQ-033 After reset, the first wrap SHALL occur on the OSF-th iq_val when ctrl_o is 0.

Configuration
REQ-034 The macro NCO_LOCK_DET_EN SHALL enable the lock detector.
REQ-035 With NCO_LOCK_DET_EN defined, on each e_valid_i: if |e_in| < LOCK_THR the counter SHALL increment, saturating at LOCK_CNT; otherwise it SHALL clear to 0 and lock_o SHALL deassert on the next cycle.
REQ-036 With NCO_LOCK_DET_EN defined, lock_o SHALL assert on the cycle after the counter reaches LOCK_CNT.
REQ-037 Without NCO_LOCK_DET_EN, lock_o SHALL be tied to 0, no counter logic SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-038 Free-run test: defaults, e_valid_i=0, iq_val=1 every cycle -> sym_valid_o on the cycle after the 20th iq_val, then every 20 cycles; mu_o=0 for the first 1000 symbols.
REQ-039 Gapped iq_val test: iq_val every other cycle -> sym_valid_o period of 40 cycles, and no strobe on a cycle whose preceding cycle had iq_val=0.
REQ-040 Loop-filter test: e_in=256 held with 10 e_valid_i pulses -> after pulse k, ctrl_o = 16 + k, one cycle later; integ = 10 at the end.
REQ-041 Saturation test: e_in=+131071 repeated 10000 times -> integ = 1048576 and ctrl_o = 1056767 (CTRL_LIM not reached); negative mirror -> integ = -1048576.
REQ-042 Mid-run reset test: reset for 1 cycle at acc≈STEP*10 with ctrl_o≠0 -> all outputs 0 on the next cycle; the next strobe comes after 20 further iq_val.
REQ-043 Lock test (macro defined): 64 e_valid_i with e_in=100 -> lock_o=1; then one e_in=600 -> lock_o=0 on the next cycle. Macro undefined -> lock_o stays 0.
